// File: rtl/rptr_sync_pkg.sv
// rtl/rptr_sync_pkg.sv - shared Gray/binary helpers and FIFO pointer width
package rptr_sync_pkg;

  // Default pointer width, shared by the read and write sides of the FIFO
  localparam int FIFO_ADDR_WIDTH = 4;

  // Binary to Gray: one bit changes per increment, safe to sample across domains
  function automatic logic [31:0] flex_bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Callers zero-extend narrower pointers, so the unused upper bits stay 0.
  function automatic logic [31:0] flex_gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a Gray-coded pointer bus
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/rptr_sync.sv
// rtl/rptr_sync.sv - read-side pointer, empty/almost-empty and underflow control
module rptr_sync
  import rptr_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  r_rst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH-1:0] wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH-1:0] rptr,
  output logic [ADDR_WIDTH-1:0] sync_wptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH-1:0] rcount,
  output logic                  underflow
);

  logic [ADDR_WIDTH-1:0] tran_waddr;
  logic [ADDR_WIDTH-1:0] raddr_next;
  logic                  pop;

  // Bring the write pointer into rclk before any decision uses it
  sync_2ff #(
    .WIDTH(ADDR_WIDTH)
  ) u_wptr_sync (
    .clk (rclk),
    .rst (r_rst),
    .d   (wptr),
    .q   (sync_wptr)
  );

  // Occupancy and flags derive only from registers, so wptr cannot glitch them
  always_comb begin
    tran_waddr   = ADDR_WIDTH'(flex_gray2bin(32'(sync_wptr)));
    empty        = (raddr == tran_waddr);
    rcount       = tran_waddr - raddr;
    almost_empty = ($unsigned(32'(rcount)) <= $unsigned(32'(AE_THRESH)));
    pop          = rinc && !empty;
    raddr_next   = pop ? raddr + 1'b1 : raddr;
  end

  // Advance the read address, publish its Gray form, latch underflow until reset
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      raddr     <= '0;
      rptr      <= '0;
      underflow <= 1'b0;
    end else begin
      raddr <= raddr_next;
      rptr  <= ADDR_WIDTH'(flex_bin2gray(32'(raddr_next)));
      if (rinc && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rptr_sync.sv
// tb/tb_rptr_sync.sv - self-checking bench for rptr_sync
module tb_rptr_sync;

  logic       rclk;
  logic       r_rst;
  logic       rinc;
  logic [3:0] wptr;
  logic [3:0] raddr;
  logic [3:0] rptr;
  logic [3:0] sync_wptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rcount;
  logic       underflow;

  int total;
  int bad;

  typedef struct {
    logic [3:0] raddr;
    logic [3:0] rptr;
    logic [3:0] swp;
    logic       empty;
    logic       ae;
    logic [3:0] cnt;
    logic       uf;
  } exp_t;

  typedef struct {
    logic rst;
    logic rinc;
    logic [3:0] wptr;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  rptr_sync #(
    .ADDR_WIDTH(4),
    .AE_THRESH (2)
  ) dut (
    .rclk        (rclk),
    .r_rst       (r_rst),
    .rinc        (rinc),
    .wptr        (wptr),
    .raddr       (raddr),
    .rptr        (rptr),
    .sync_wptr   (sync_wptr),
    .empty       (empty),
    .almost_empty(almost_empty),
    .rcount      (rcount),
    .underflow   (underflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t mk_e(input logic [3:0] ra, input logic [3:0] rp,
                                input logic [3:0] sw, input logic em,
                                input logic ae, input logic [3:0] cnt,
                                input logic uf);
    exp_t e;
    e.raddr = ra; e.rptr = rp; e.swp = sw; e.empty = em;
    e.ae = ae; e.cnt = cnt; e.uf = uf;
    return e;
  endfunction

  function automatic vec_t mk(input logic rst_i, input logic rinc_i,
                              input logic [3:0] wptr_i, input exp_t e);
    vec_t v;
    v.rst = rst_i; v.rinc = rinc_i; v.wptr = wptr_i; v.e = e;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int req, input int step_no);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, step_no, act, req);
    end
  endtask

  int step_no = 0;

  task automatic step(input logic rst_i, input logic rinc_i,
                      input logic [3:0] wptr_i, input exp_t e);
    exp_t x;
    @(negedge rclk);
    r_rst = rst_i;
    rinc  = rinc_i;
    wptr  = wptr_i;
    sb.push_back(e);
    @(posedge rclk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 1, 0, step_no);
    end else begin
      x = sb.pop_front();
      cmp("raddr",        int'(raddr),        int'(x.raddr), step_no);
      cmp("rptr",         int'(rptr),         int'(x.rptr),  step_no);
      cmp("sync_wptr",    int'(sync_wptr),    int'(x.swp),   step_no);
      cmp("empty",        int'(empty),        int'(x.empty), step_no);
      cmp("almost_empty", int'(almost_empty), int'(x.ae),    step_no);
      cmp("rcount",       int'(rcount),       int'(x.cnt),   step_no);
      cmp("underflow",    int'(underflow),    int'(x.uf),    step_no);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    r_rst = 1'b1;
    rinc  = 1'b0;
    wptr  = 4'b0000;

    // reset, sync latency, drain with underflow, threshold crossing
    tbl.push_back(mk(1, 0, 4'b0000, mk_e(0, 4'b0000, 4'b0000, 1, 1, 0, 0)));
    tbl.push_back(mk(1, 0, 4'b0000, mk_e(0, 4'b0000, 4'b0000, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 4'b0001, mk_e(0, 4'b0000, 4'b0000, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 0, 4'b0001, mk_e(0, 4'b0000, 4'b0001, 0, 1, 1, 0)));
    tbl.push_back(mk(0, 0, 4'b0111, mk_e(0, 4'b0000, 4'b0001, 0, 1, 1, 0)));
    tbl.push_back(mk(0, 0, 4'b0111, mk_e(0, 4'b0000, 4'b0111, 0, 0, 5, 0)));
    tbl.push_back(mk(0, 1, 4'b0111, mk_e(1, 4'b0001, 4'b0111, 0, 0, 4, 0)));
    tbl.push_back(mk(0, 1, 4'b0111, mk_e(2, 4'b0011, 4'b0111, 0, 0, 3, 0)));
    tbl.push_back(mk(0, 1, 4'b0111, mk_e(3, 4'b0010, 4'b0111, 0, 1, 2, 0)));
    tbl.push_back(mk(0, 1, 4'b0111, mk_e(4, 4'b0110, 4'b0111, 0, 1, 1, 0)));
    tbl.push_back(mk(0, 1, 4'b0111, mk_e(5, 4'b0111, 4'b0111, 1, 1, 0, 0)));
    tbl.push_back(mk(0, 1, 4'b0111, mk_e(5, 4'b0111, 4'b0111, 1, 1, 0, 1)));
    tbl.push_back(mk(0, 0, 4'b0111, mk_e(5, 4'b0111, 4'b0111, 1, 1, 0, 1)));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].rinc, tbl[i].wptr, tbl[i].e);
    end

    // move raddr up to 14 by writing to bin 14 and draining
    step(0, 0, 4'b1001, mk_e(5, 4'b0111, 4'b0111, 1, 1, 0, 1));
    step(0, 0, 4'b1001, mk_e(5, 4'b0111, 4'b1001, 0, 0, 9, 1));
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 4'b1001, mk_e(4'(6 + i), g(4'(6 + i)), 4'b1001, (i == 8),
                               ((8 - i) <= 2), 4'(8 - i), 1));
    end

    // wrap-around: writer at bin 2, reader at 14
    step(0, 0, 4'b0011, mk_e(14, 4'b1001, 4'b1001, 1, 1, 0, 1));
    step(0, 0, 4'b0011, mk_e(14, 4'b1001, 4'b0011, 0, 0, 4, 1));
    step(0, 1, 4'b0011, mk_e(15, 4'b1000, 4'b0011, 0, 0, 3, 1));
    step(0, 1, 4'b0011, mk_e(0,  4'b0000, 4'b0011, 0, 1, 2, 1));
    step(0, 1, 4'b0011, mk_e(1,  4'b0001, 4'b0011, 0, 1, 1, 1));
    step(0, 1, 4'b0011, mk_e(2,  4'b0011, 4'b0011, 1, 1, 0, 1));

    // bring raddr to 7 with writer at bin 8
    step(0, 0, 4'b1100, mk_e(2, 4'b0011, 4'b0011, 1, 1, 0, 1));
    step(0, 0, 4'b1100, mk_e(2, 4'b0011, 4'b1100, 0, 0, 6, 1));
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'b1100, mk_e(4'(3 + i), g(4'(3 + i)), 4'b1100, 0,
                               ((5 - i) <= 2), 4'(5 - i), 1));
    end

    // reset mid-operation with a pop request: reset wins
    step(1, 1, 4'b1100, mk_e(0, 4'b0000, 4'b0000, 1, 1, 0, 0));
    step(0, 0, 4'b1100, mk_e(0, 4'b0000, 4'b0000, 1, 1, 0, 0));
    step(0, 0, 4'b1100, mk_e(0, 4'b0000, 4'b1100, 0, 0, 8, 0));

    cmp("scoreboard_drained", sb.size(), 0, step_no);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
